// File: rtl/nand_seq_pkg.sv
// rtl/nand_seq_pkg.sv - opcodes, step table, state and operand-select encodings for nand_seq_ctrl
package nand_seq_pkg;

    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_NOTA = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_A  = 3'd0,
        SEL_B  = 3'd1,
        SEL_T1 = 3'd2,
        SEL_T2 = 3'd3,
        SEL_T3 = 3'd4
    } sel_e;

    typedef enum logic [1:0] {
        DST_T1 = 2'd0,
        DST_T2 = 2'd1,
        DST_T3 = 2'd2,
        DST_Y  = 2'd3
    } dst_e;

    typedef struct packed {
        sel_e p;
        sel_e q;
        dst_e dst;
    } step_t;

    // Zero steps marks an illegal opcode.
    function automatic logic [2:0] op_steps(input logic [2:0] op);
        case (op)
            OP_NAND: return 3'd1;
            OP_NOTA: return 3'd1;
            OP_AND:  return 3'd2;
            OP_OR:   return 3'd3;
            OP_XOR:  return 3'd4;
            OP_XNOR: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return op_steps(op) != 3'd0;
    endfunction

    function automatic step_t mk_step(input sel_e p, input sel_e q, input dst_e d);
        step_t s;
        s.p   = p;
        s.q   = q;
        s.dst = d;
        return s;
    endfunction

    function automatic step_t step_plan(input logic [2:0] op, input logic [2:0] step);
        step_t s;
        s = mk_step(SEL_A, SEL_A, DST_Y);
        case (op)
            OP_NAND: s = mk_step(SEL_A, SEL_B, DST_Y);
            OP_NOTA: s = mk_step(SEL_A, SEL_A, DST_Y);
            OP_AND: begin
                if (step == 3'd0) s = mk_step(SEL_A, SEL_B, DST_T1);
                else              s = mk_step(SEL_T1, SEL_T1, DST_Y);
            end
            OP_OR: begin
                case (step)
                    3'd0:    s = mk_step(SEL_A, SEL_A, DST_T1);
                    3'd1:    s = mk_step(SEL_B, SEL_B, DST_T2);
                    default: s = mk_step(SEL_T1, SEL_T2, DST_Y);
                endcase
            end
            OP_XOR, OP_XNOR: begin
                case (step)
                    3'd0: s = mk_step(SEL_A, SEL_B, DST_T1);
                    3'd1: s = mk_step(SEL_A, SEL_T1, DST_T2);
                    3'd2: s = mk_step(SEL_B, SEL_T1, DST_T3);
                    3'd3: s = mk_step(SEL_T2, SEL_T3, (op == OP_XOR) ? DST_Y : DST_T1);
                    default: s = mk_step(SEL_T1, SEL_T1, DST_Y);
                endcase
            end
            default: s = mk_step(SEL_A, SEL_A, DST_Y);
        endcase
        return s;
    endfunction

endpackage

// File: rtl/nand_vec.sv
// rtl/nand_vec.sv - combinational WIDTH-bit bitwise NAND array
module nand_vec #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] n
);

    assign n = ~(p & q);

endmodule

// File: rtl/nand_seq_ctrl.sv
// rtl/nand_seq_ctrl.sv - sequences bitwise logic ops as multi-cycle NAND steps on one shared array
module nand_seq_ctrl
    import nand_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] nand_count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
    logic [2:0]       rop_q, rop_d;
    logic [WIDTH-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
    logic [2:0]       step_q, step_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    step_t            plan;
    logic [WIDTH-1:0] p_op, q_op, n_out;

    assign plan = step_plan(rop_q, step_q);

    always_comb begin
        p_op = ra_q;
        case (plan.p)
            SEL_A:   p_op = ra_q;
            SEL_B:   p_op = rb_q;
            SEL_T1:  p_op = t1_q;
            SEL_T2:  p_op = t2_q;
            SEL_T3:  p_op = t3_q;
            default: p_op = ra_q;
        endcase
    end

    always_comb begin
        q_op = ra_q;
        case (plan.q)
            SEL_A:   q_op = ra_q;
            SEL_B:   q_op = rb_q;
            SEL_T1:  q_op = t1_q;
            SEL_T2:  q_op = t2_q;
            SEL_T3:  q_op = t3_q;
            default: q_op = ra_q;
        endcase
    end

    nand_vec #(.WIDTH(WIDTH)) u_nand (
        .p (p_op),
        .q (q_op),
        .n (n_out)
    );

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rop_d   = rop_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        t3_d    = t3_q;
        step_d  = step_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ra_d   = a;
                    rb_d   = b;
                    rop_d  = op;
                    step_d = 3'd0;
                    if (op_legal(op)) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                    end else begin
                        // Illegal ops skip RUN entirely; y is left untouched.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                case (plan.dst)
                    DST_T1:  t1_d = n_out;
                    DST_T2:  t2_d = n_out;
                    DST_T3:  t3_d = n_out;
                    default: y_d  = n_out;
                endcase
                step_d = step_q + 3'd1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (step_q == op_steps(rop_q) - 3'd1) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rop_q   <= 3'd0;
            t1_q    <= '0;
            t2_q    <= '0;
            t3_q    <= '0;
            step_q  <= 3'd0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rop_q   <= rop_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            t3_q    <= t3_d;
            step_q  <= step_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign y          = y_q;
    assign nand_count = cnt_q;

endmodule

// File: tb/tb_nand_seq_ctrl.sv
// tb/tb_nand_seq_ctrl.sv - randomized and directed self-checking bench for nand_seq_ctrl
module tb_nand_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  a, b;

    logic        busy, done, err;
    logic [7:0]  y;
    logic [15:0] nand_count;

    logic        busy4, done4, err4;
    logic [7:0]  y4;
    logic [3:0]  nand_count4;

    int          compared   = 0;
    int          mismatched = 0;
    logic [7:0]  y_exp;
    int          total;

    always #5 clk = ~clk;

    nand_seq_ctrl #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .y          (y),
        .nand_count (nand_count)
    );

    nand_seq_ctrl #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy4),
        .done       (done4),
        .err        (err4),
        .y          (y4),
        .nand_count (nand_count4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_k(input logic [2:0] o);
        int kt [8] = '{1, 1, 2, 3, 4, 5, 0, 0};
        return kt[o];
    endfunction

    function automatic logic [7:0] ref_y(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0:    return ~(x & z);
            3'd1:    return ~x;
            3'd2:    return x & z;
            3'd3:    return x | z;
            3'd4:    return x ^ z;
            default: return ~(x ^ z);
        endcase
    endfunction

    function automatic logic [31:0] sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic run(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z,
                       input bit poke_run, input bit poke_done);
        int k, lat, bcyc;
        k = ref_k(o);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = z;
        @(negedge clk);
        start = 1'b0; lat = 1; bcyc = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcyc++;
            if (poke_run && lat == 1) begin
                start = 1'b1; op = 3'($urandom); a = ~x; b = ~z;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        if (k != 0) begin
            y_exp = ref_y(o, x, z);
            total += k;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("latency", lat, k + 1);
        check("busy_cycles", bcyc, k);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("y", {24'd0, y}, {24'd0, y_exp});
        check("err", {31'd0, err}, (k == 0) ? 32'd1 : 32'd0);
        check("count16", {16'd0, nand_count}, sat(total, 65535));
        check("count4", {28'd0, nand_count4}, sat(total, 15));
        if (poke_done) begin
            start = 1'b1; op = 3'd0; a = ~x; b = ~z;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("y_hold", {24'd0, y}, {24'd0, y_exp});
        if (poke_done) begin
            @(negedge clk);
            check("no_extra_done", {31'd0, done}, 32'd0);
            check("no_extra_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0;
        y_exp = 8'd0; total = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_y", {24'd0, y}, 32'd0);
        check("rst_count", {16'd0, nand_count}, 32'd0);
        rst = 1'b0;

        run(3'd0, 8'hCC, 8'hAA, 0, 0);
        check("nand_val", {24'd0, y}, 32'h77);
        run(3'd2, 8'hCC, 8'hAA, 0, 0);
        check("and_val", {24'd0, y}, 32'h88);
        run(3'd3, 8'hCC, 8'hAA, 0, 0);
        check("or_val", {24'd0, y}, 32'hEE);
        run(3'd4, 8'hCC, 8'hAA, 0, 0);
        check("xor_val", {24'd0, y}, 32'h66);
        run(3'd5, 8'hCC, 8'hAA, 0, 0);
        check("xnor_val", {24'd0, y}, 32'h99);
        check("count_15", {16'd0, nand_count}, 32'd15);
        run(3'd1, 8'hCC, 8'h5A, 0, 0);
        check("nota_val", {24'd0, y}, 32'h33);
        run(3'd6, 8'h12, 8'h34, 0, 0);
        check("illegal_y", {24'd0, y}, 32'h33);
        run(3'd7, 8'h56, 8'h78, 0, 1);
        run(3'd0, 8'h0F, 8'h3C, 0, 0);
        check("err_cleared", {31'd0, err}, 32'd0);

        run(3'd4, 8'hCC, 8'hAA, 1, 0);
        run(3'd0, 8'hF0, 8'h0F, 0, 1);
        run(3'd5, 8'h81, 8'hC3, 1, 1);

        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 8'hCC; b = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_y", {24'd0, y}, 32'd0);
        check("arst_count", {16'd0, nand_count}, 32'd0);
        check("arst_count4", {28'd0, nand_count4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        total = 0; y_exp = 8'd0;
        run(3'd0, 8'hCC, 8'hAA, 0, 0);
        check("post_rst_nand", {24'd0, y}, 32'h77);

        for (int i = 0; i < 30; i++) begin
            run(3'($urandom), 8'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 20; i++) begin
            run(3'd0, 8'($urandom), 8'($urandom), 0, 0);
        end
        check("sat4", {28'd0, nand_count4}, 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
